// File: rtl/uart_tx_piso_if.sv
// Byte handshake between a transmit source and the UART transmitter.
//   tx_data  : byte offered by the source, sampled only on a transfer
//   tx_valid : source has a byte on tx_data
//   tx_ready : transmitter can accept a byte this cycle
// A transfer happens on a rising clk edge where tx_valid && tx_ready.
interface uart_tx_piso_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_piso.sv
// UART transmitter: parallel-in, serial-out with 8N1/8N2 framing and an
// internal baud counter. Start bit, 8 data bits LSB first, then stop bit(s).
// Ports:
//   clk    : system clock, all logic on the rising edge
//   reset  : synchronous, active-high; aborts any frame in progress
//   tx_if  : byte handshake (slave side: tx_data, tx_valid in; tx_ready out)
//   tx     : registered serial line, idles high
//   busy   : high in any state other than IDLE
//
// state | meaning
// IDLE  | line high, tx_ready=1, waiting for a byte
// START | start bit (line low) for one bit period
// DATA  | 8 data bits, shift register bit 0 on the line
// STOP  | line high for STOP_BITS bit periods
module uart_tx_piso #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_piso_if.slave  tx_if,
    output logic           tx,
    output logic           busy
);

    localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_done;

    assign bit_done       = (baud_cnt_q == CNT_LAST);
    assign tx_if.tx_ready = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign tx             = tx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = bit_done ? '0 : baud_cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                if (tx_if.tx_valid) begin
                    shift_d = tx_if.tx_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    // index wraps 7 -> 0, so STOP reuses it to count stop bits
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (bit_idx_q == STOP_LAST) begin
                        state_d   = IDLE;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state so tx is a clean register output
        // and the start bit appears on the accepting edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_piso.sv
module tb_uart_tx_piso;

    logic clk;
    logic reset;
    logic tx_a, busy_a;
    logic tx_b, busy_b;
    int   pass_cnt;
    int   total_cnt;

    uart_tx_piso_if if_a ();
    uart_tx_piso_if if_b ();

    uart_tx_piso #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .tx_if (if_a),
        .tx    (tx_a),
        .busy  (busy_a)
    );

    uart_tx_piso #(.CLKS_PER_BIT(8), .STOP_BITS(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .tx_if (if_b),
        .tx    (tx_b),
        .busy  (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level j cycles after the accepting edge.
    function automatic logic frame_bit(input logic [7:0] b, input int j,
                                       input int c, input int s);
        if (j < c)           return 1'b0;
        else if (j < 9 * c)  return b[(j - c) / c];
        else                 return 1'b1;
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        if_a.tx_valid = 1'b0;
        if_a.tx_data  = 8'h00;
        if_b.tx_valid = 1'b0;
        if_b.tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            total_cnt++;
            if ({tx_a, busy_a, if_a.tx_ready} !== 3'b101 ||
                {tx_b, busy_b, if_b.tx_ready} !== 3'b101)
                $display("FAIL reset_idle cyc=%0d a(tx,busy,rdy)=%b%b%b b=%b%b%b want 101",
                         i, tx_a, busy_a, if_a.tx_ready, tx_b, busy_b, if_b.tx_ready);
            else pass_cnt++;
            advance();
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] b;
        b = 8'hA5;
        if_a.tx_data  = b;
        if_a.tx_valid = 1'b1;
        advance();
        if_a.tx_valid = 1'b0;
        for (int j = 0; j < 40; j++) begin
            total_cnt++;
            if (tx_a !== frame_bit(b, j, 4, 1) || if_a.tx_ready !== 1'b0 || busy_a !== 1'b1)
                $display("FAIL single_a5 j=%0d tx=%b rdy=%b busy=%b want tx=%b rdy=0 busy=1",
                         j, tx_a, if_a.tx_ready, busy_a, frame_bit(b, j, 4, 1));
            else pass_cnt++;
            advance();
        end
        total_cnt++;
        if ({tx_a, busy_a, if_a.tx_ready} !== 3'b101)
            $display("FAIL single_ready_at_40 got=%b%b%b want 101", tx_a, busy_a, if_a.tx_ready);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic exp;
        if_a.tx_data  = 8'h00;
        if_a.tx_valid = 1'b1;
        advance();
        if_a.tx_data  = 8'hFF;
        for (int j = 0; j < 81; j++) begin
            if (j < 40)       exp = frame_bit(8'h00, j, 4, 1);
            else if (j == 40) exp = 1'b1;
            else              exp = frame_bit(8'hFF, j - 41, 4, 1);
            total_cnt++;
            if (tx_a !== exp || if_a.tx_ready !== (j == 40))
                $display("FAIL b2b j=%0d tx=%b rdy=%b want tx=%b rdy=%b",
                         j, tx_a, if_a.tx_ready, exp, (j == 40));
            else pass_cnt++;
            if (j == 41) if_a.tx_valid = 1'b0;
            advance();
        end
        total_cnt++;
        if ({tx_a, busy_a, if_a.tx_ready} !== 3'b101)
            $display("FAIL b2b_end got=%b%b%b want 101", tx_a, busy_a, if_a.tx_ready);
        else pass_cnt++;
    endtask

    task automatic test_data_stability();
        if_a.tx_data  = 8'h81;
        if_a.tx_valid = 1'b1;
        advance();
        if_a.tx_data  = 8'h3C;
        if_a.tx_valid = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (j == 10) if_a.tx_valid = 1'b1;
            if (j == 12) if_a.tx_valid = 1'b0;
            total_cnt++;
            if (tx_a !== frame_bit(8'h81, j, 4, 1))
                $display("FAIL stable_81 j=%0d tx=%b want %b", j, tx_a, frame_bit(8'h81, j, 4, 1));
            else pass_cnt++;
            advance();
        end
        for (int j = 0; j < 6; j++) begin
            total_cnt++;
            if ({tx_a, busy_a, if_a.tx_ready} !== 3'b101)
                $display("FAIL stable_no_second_frame cyc=%0d got=%b%b%b want 101",
                         j, tx_a, busy_a, if_a.tx_ready);
            else pass_cnt++;
            advance();
        end
    endtask

    task automatic test_reset_mid_frame();
        if_a.tx_data  = 8'h55;
        if_a.tx_valid = 1'b1;
        advance();
        if_a.tx_valid = 1'b0;
        for (int j = 0; j < 17; j++) begin
            total_cnt++;
            if (tx_a !== frame_bit(8'h55, j, 4, 1))
                $display("FAIL abort_55 j=%0d tx=%b want %b", j, tx_a, frame_bit(8'h55, j, 4, 1));
            else pass_cnt++;
            advance();
        end
        reset = 1'b1;
        advance();
        total_cnt++;
        if ({tx_a, busy_a, if_a.tx_ready} !== 3'b101)
            $display("FAIL abort_reset got=%b%b%b want 101", tx_a, busy_a, if_a.tx_ready);
        else pass_cnt++;

        if_a.tx_data  = 8'hC3;
        if_a.tx_valid = 1'b1;
        advance();
        total_cnt++;
        if ({tx_a, busy_a, if_a.tx_ready} !== 3'b101)
            $display("FAIL reset_vs_valid got=%b%b%b want 101", tx_a, busy_a, if_a.tx_ready);
        else pass_cnt++;
        if_a.tx_valid = 1'b0;
        reset         = 1'b0;
        advance();
        total_cnt++;
        if ({tx_a, busy_a, if_a.tx_ready} !== 3'b101)
            $display("FAIL reset_vs_valid_after got=%b%b%b want 101", tx_a, busy_a, if_a.tx_ready);
        else pass_cnt++;

        if_a.tx_data  = 8'h0F;
        if_a.tx_valid = 1'b1;
        advance();
        if_a.tx_valid = 1'b0;
        for (int j = 0; j < 40; j++) begin
            total_cnt++;
            if (tx_a !== frame_bit(8'h0F, j, 4, 1) || busy_a !== 1'b1)
                $display("FAIL fresh_0f j=%0d tx=%b busy=%b want tx=%b busy=1",
                         j, tx_a, busy_a, frame_bit(8'h0F, j, 4, 1));
            else pass_cnt++;
            advance();
        end
        total_cnt++;
        if ({tx_a, busy_a, if_a.tx_ready} !== 3'b101)
            $display("FAIL fresh_0f_end got=%b%b%b want 101", tx_a, busy_a, if_a.tx_ready);
        else pass_cnt++;
    endtask

    task automatic test_two_stop_loopback();
        logic [7:0] b;
        logic [7:0] rx;
        int         stop_hi;
        int         n;
        b       = 8'h5A;
        rx      = 8'h00;
        stop_hi = 0;
        n       = 0;
        while (if_b.tx_ready !== 1'b1 && n < 2000) begin
            advance();
            n++;
        end
        total_cnt++;
        if (if_b.tx_ready !== 1'b1)
            $display("FAIL loop_wait_ready rdy=%b want 1", if_b.tx_ready);
        else pass_cnt++;
        if_b.tx_data  = b;
        if_b.tx_valid = 1'b1;
        advance();
        if_b.tx_valid = 1'b0;
        for (int j = 0; j < 88; j++) begin
            total_cnt++;
            if (tx_b !== frame_bit(b, j, 8, 2) || busy_b !== 1'b1)
                $display("FAIL frame_5a j=%0d tx=%b busy=%b want tx=%b busy=1",
                         j, tx_b, busy_b, frame_bit(b, j, 8, 2));
            else pass_cnt++;
            // receiver samples mid-bit and shifts new bits in at the MSB
            if (j >= 8 && j < 72 && (j % 8) == 4) rx = {tx_b, rx[7:1]};
            if (j >= 72 && tx_b === 1'b1) stop_hi++;
            advance();
        end
        total_cnt++;
        if ({tx_b, busy_b, if_b.tx_ready} !== 3'b101)
            $display("FAIL frame_88_end got=%b%b%b want 101", tx_b, busy_b, if_b.tx_ready);
        else pass_cnt++;
        total_cnt++;
        if (stop_hi !== 16)
            $display("FAIL stop_len got=%0d want 16", stop_hi);
        else pass_cnt++;
        total_cnt++;
        if (rx !== 8'h5A)
            $display("FAIL loopback got=%h want 5a", rx);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_single_byte();
        advance();
        test_back_to_back();
        test_data_stability();
        test_reset_mid_frame();
        test_two_stop_loopback();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_piso.md
Name: uart_tx_piso

Overview:
- UART transmit path: the transmit-side counterpart of the RX SIPO path. Parallel-in, serial-out with built-in framing.
- Accepts a byte over a valid/ready handshake and serialises it as 8N1 (or 8N2): start bit, 8 data bits LSB first, then stop bit(s).
- Has its own baud-rate counter, so no external tick is needed.
- Sits between the pattern-matching logic and the TX pin.
- LSB-first order matches the RX shift direction (new bit enters at MSB, oldest bit ends at LSB), so loopback returns the original byte.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range ≥ 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk       input   1  system clock; all logic on its rising edge.
- reset     input   1  synchronous, active-high reset.
- tx_data   input   8  byte to send; sampled only on handshake.
- tx_valid  input   1  source has a byte on tx_data.
- tx_ready  output  1  block can accept a byte this cycle.
- tx        output  1  serial line; idles high.
- busy      output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high; all state changes happen on the rising edge of clk.
  - Reset values: state=IDLE, tx=1, busy=0, tx_ready=1, baud counter=0, bit index=0, shift register=0.
  - Reset mid-frame aborts the frame. tx returns to 1 on the reset edge and the latched byte is discarded. There is no partial-frame completion.
- State machine: IDLE → START → DATA → STOP → IDLE.
  - tx_ready = (state==IDLE); it is registered or derived only from state, never combinationally from tx_valid.
  - Handshake: a transfer occurs on an edge where tx_valid && tx_ready.
    - On that edge: latch tx_data into the shift register, clear the baud counter, enter START.
  - tx_valid while tx_ready=0 is ignored. There is no queuing; the source holds tx_valid and tx_data until it sees ready.
  - tx_data changes after the handshake have no effect on the frame.
- Timing:
  - tx is registered. It drops to 0 on the same edge that accepts the byte, so the start bit is visible one cycle after the handshake cycle.
  - Each bit is held exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1; the bit advances when the counter hits CLKS_PER_BIT-1, and the counter wraps to 0.
  - START: tx=0 for one bit period, then DATA.
  - DATA:
    - tx = shift register bit 0.
    - At the end of each bit: shift right by 1 and increment the bit index (0..7).
    - After bit index 7 completes, go to STOP.
  - STOP: tx=1 for STOP_BITS × CLKS_PER_BIT cycles, then IDLE.
- Frame length and spacing:
  - The line is low/high per the frame for exactly (9+STOP_BITS)×CLKS_PER_BIT cycles.
  - IDLE lasts at least one cycle, so back-to-back start bits are spaced (9+STOP_BITS)×CLKS_PER_BIT + 1 cycles.
- busy is high from the accepting edge through the final stop cycle. It is low in the same cycle tx_ready is high.
- Boundary conditions:
  - tx_valid held high continuously → frames are sent back-to-back at minimum spacing.
  - tx_valid asserted and reset high on the same edge → reset wins; the byte is not accepted.
- Counters:
  - The baud counter is sized $clog2(CLKS_PER_BIT) bits and must not overflow for any legal parameter.
  - The bit index is 3 bits.

Test Plan:
- Reset, then idle: hold reset 3 cycles, release, no tx_valid for 20 cycles → tx=1, busy=0, tx_ready=1 throughout.
- Single byte (CLKS_PER_BIT=4, STOP_BITS=1): send 0xA5 →
  - tx=0 for 4 cycles starting the cycle after the handshake;
  - then bits 1,0,1,0,0,1,0,1, each 4 cycles;
  - then 1 for 4 cycles;
  - tx_ready returns high 40 cycles after the handshake.
- Back-to-back: tx_valid held high with 0x00 then 0xFF → the second start bit begins exactly 41 cycles after the first; all data bits are correct.
- Data stability: change tx_data to 0x3C one cycle after accepting 0x81; pulse tx_valid while busy → serialised bits stay 0x81 and no second frame starts.
- Reset mid-frame: assert reset during data bit 3 of 0x55 → tx=1, busy=0, tx_ready=1 on the next edge; a fresh 0x0F afterwards is sent cleanly.
- Two stop bits and loopback (STOP_BITS=2, CLKS_PER_BIT=8):
  - send 0x5A → stop high for 16 cycles, frame = 88 cycles;
  - feed tx into the RX SIPO path → recovered byte equals 0x5A.
